// File: rtl/rst_seq_if.sv
// Handshake/status bundle between a reset requester and the reset sequencer.
interface rst_seq_if #(
  parameter int unsigned P_CH = 4
);
  logic            i_req;
  logic [P_CH-1:0] i_req_mask;
  logic [P_CH-1:0] o_rst;
  logic            o_done;
  logic            o_busy;

  modport master (
    output i_req,
    output i_req_mask,
    input  o_rst,
    input  o_done,
    input  o_busy
  );

  modport slave (
    input  i_req,
    input  i_req_mask,
    output o_rst,
    output o_done,
    output o_busy
  );
endinterface

// File: rtl/rst_seq_module.sv
// Multi-channel reset sequencer: holds all channels, then releases them in
// index order with a fixed stagger. Requests may mask channels so they keep
// running; the master reset always resets every channel.
module rst_seq_module #(
  parameter int unsigned P_CH         = 4,
  parameter int unsigned P_HOLD_CYCLE = 16,
  parameter int unsigned P_STAGGER    = 8,
  parameter int unsigned P_CNT_W      = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  rst_seq_if.slave   bus
);

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_RELEASE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  localparam logic [P_CNT_W-1:0] CNT_MAX = '1;

  state_t              state_q, state_d;
  logic [P_CNT_W-1:0]  cnt_q, cnt_d;
  logic [P_CH-1:0]     r_mask_q, r_mask_d;
  logic [P_CH-1:0]     o_rst_q, o_rst_d;
  logic                o_done_q, o_done_d;
  logic                o_busy_q, o_busy_d;
  logic [P_CH-1:0]     rel_hit_c;

  // Channel k is due for release once the elapsed count reaches its slot.
  always_comb begin
    rel_hit_c = '0;
    for (int unsigned k = 0; k < P_CH; k++) begin
      rel_hit_c[k] = (cnt_q >= P_CNT_W'(P_HOLD_CYCLE + k * P_STAGGER));
    end
  end

  // Next-state: request restarts the timeline, otherwise sequence releases.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    r_mask_d = r_mask_q;
    o_rst_d  = o_rst_q;
    o_done_d = o_done_q;

    if (bus.i_req) begin
      r_mask_d = bus.i_req_mask;
      o_rst_d  = ~bus.i_req_mask;
      o_done_d = 1'b0;
      state_d  = S_HOLD;
      cnt_d    = '0;
    end else begin
      case (state_q)
        S_HOLD, S_RELEASE: begin
          // Saturating count: the timeline never wraps back into a slot.
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + P_CNT_W'(1);
          end
          o_rst_d = o_rst_q & ~rel_hit_c;
          if (rel_hit_c[P_CH-1]) begin
            state_d  = S_DONE;
            o_done_d = 1'b1;
          end else if (rel_hit_c[0]) begin
            state_d  = S_RELEASE;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end

    o_busy_d = ~o_done_d;
  end

  // State and output registers; master reset has top priority.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_HOLD;
      cnt_q    <= '0;
      r_mask_q <= '0;
      o_rst_q  <= '1;
      o_done_q <= 1'b0;
      o_busy_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      r_mask_q <= r_mask_d;
      o_rst_q  <= o_rst_d;
      o_done_q <= o_done_d;
      o_busy_q <= o_busy_d;
    end
  end

  assign bus.o_rst  = o_rst_q;
  assign bus.o_done = o_done_q;
  assign bus.o_busy = o_busy_q;

endmodule

// File: tb/tb_rst_seq_module.sv
// Directed bench for rst_seq_module: default, zero-delay and long-hold variants.
module tb_rst_seq_module;

  logic clk;
  logic rst_a, rst_b, rst_c;
  int   n_pass;
  int   n_chk;
  int   now_n;

  rst_seq_if #(.P_CH(4)) if_a ();
  rst_seq_if #(.P_CH(4)) if_b ();
  rst_seq_if #(.P_CH(1)) if_c ();

  rst_seq_module #(.P_CH(4), .P_HOLD_CYCLE(16), .P_STAGGER(8), .P_CNT_W(16)) dut_a (
    .i_clk (clk), .i_rst (rst_a), .bus (if_a.slave)
  );
  rst_seq_module #(.P_CH(4), .P_HOLD_CYCLE(0), .P_STAGGER(0), .P_CNT_W(16)) dut_b (
    .i_clk (clk), .i_rst (rst_b), .bus (if_b.slave)
  );
  rst_seq_module #(.P_CH(1), .P_HOLD_CYCLE(255), .P_STAGGER(8), .P_CNT_W(8)) dut_c (
    .i_clk (clk), .i_rst (rst_c), .bus (if_c.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int       n;
    logic [3:0] rst;
    logic     done;
  } vec_t;

  vec_t v1 [8];
  vec_t v3 [6];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b want %b (t=%0t)", nm, act, exp, $time);
  endtask

  // Advance to 1 time unit after edge T+n.
  task automatic run_to(input int n);
    while (now_n < n) begin
      @(posedge clk);
      now_n++;
    end
    #1;
  endtask

  task automatic chk_a(input string nm, input logic [3:0] er, input logic ed);
    chk({nm, ".rst"},  {4'b0, if_a.o_rst}, {4'b0, er});
    chk({nm, ".done"}, {7'b0, if_a.o_done}, {7'b0, ed});
    chk({nm, ".busy"}, {7'b0, if_a.o_busy}, {7'b0, ~ed});
  endtask

  initial begin
    logic bad;
    n_pass = 0;
    n_chk  = 0;
    now_n  = 0;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    if_a.i_req = 1'b0; if_a.i_req_mask = 4'b0000;
    if_b.i_req = 1'b0; if_b.i_req_mask = 4'b0000;
    if_c.i_req = 1'b0; if_c.i_req_mask = 1'b0;

    v1[0] = '{16, 4'b1111, 1'b0};
    v1[1] = '{17, 4'b1110, 1'b0};
    v1[2] = '{24, 4'b1110, 1'b0};
    v1[3] = '{25, 4'b1100, 1'b0};
    v1[4] = '{32, 4'b1100, 1'b0};
    v1[5] = '{33, 4'b1000, 1'b0};
    v1[6] = '{40, 4'b1000, 1'b0};
    v1[7] = '{41, 4'b0000, 1'b1};

    v3[0] = '{1,  4'b1010, 1'b0};
    v3[1] = '{24, 4'b1010, 1'b0};
    v3[2] = '{25, 4'b1000, 1'b0};
    v3[3] = '{40, 4'b1000, 1'b0};
    v3[4] = '{41, 4'b0000, 1'b1};
    v3[5] = '{60, 4'b0000, 1'b1};

    repeat (3) @(posedge clk);
    #1;

    // Test 1: master reset then staggered release.
    rst_a = 1'b1;
    @(posedge clk); #1; rst_a = 1'b0; now_n = 0;
    chk_a("t1_reset", 4'b1111, 1'b0);
    for (int i = 0; i < 8; i++) begin
      run_to(v1[i].n);
      chk_a($sformatf("t1_n%0d", v1[i].n), v1[i].rst, v1[i].done);
    end

    // Test 3: masked request pulse from DONE.
    run_to(50);
    if_a.i_req = 1'b1; if_a.i_req_mask = 4'b0101;
    @(posedge clk); #1; if_a.i_req = 1'b0; if_a.i_req_mask = 4'b0000; now_n = 0;
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      while (now_n < v3[i].n) begin
        @(posedge clk); now_n++;
        #1;
        if ((if_a.o_rst & 4'b0101) != 4'b0000) bad = 1'b1;
      end
      chk_a($sformatf("t3_n%0d", v3[i].n), v3[i].rst, v3[i].done);
    end
    chk("t3_masked_low", {7'b0, bad}, 8'd0);

    // Test 4: unmasked request after channel 0 released restarts timeline.
    rst_a = 1'b1;
    @(posedge clk); #1; rst_a = 1'b0; now_n = 0;
    run_to(19);
    chk_a("t4_pre", 4'b1110, 1'b0);
    if_a.i_req = 1'b1; if_a.i_req_mask = 4'b0000;
    @(posedge clk); #1; if_a.i_req = 1'b0; now_n = 0;
    run_to(1);
    chk_a("t4_n1", 4'b1111, 1'b0);
    run_to(16);
    chk_a("t4_n16", 4'b1111, 1'b0);
    run_to(17);
    chk_a("t4_n17", 4'b1110, 1'b0);

    // Level-held request keeps restarting the count.
    if_a.i_req = 1'b1; if_a.i_req_mask = 4'b0010;
    repeat (30) @(posedge clk);
    #1;
    chk_a("t4_level", 4'b1101, 1'b0);
    if_a.i_req = 1'b0; if_a.i_req_mask = 4'b0000; now_n = 0;
    run_to(16);
    chk_a("t4_level_n16", 4'b1101, 1'b0);
    run_to(17);
    chk_a("t4_level_n17", 4'b1100, 1'b0);

    // Test 5: master reset during a masked request sequence.
    if_a.i_req = 1'b1; if_a.i_req_mask = 4'b0101;
    @(posedge clk); #1; if_a.i_req = 1'b0; if_a.i_req_mask = 4'b0000; now_n = 0;
    run_to(10);
    chk_a("t5_pre", 4'b1010, 1'b0);
    rst_a = 1'b1;
    @(posedge clk); #1; rst_a = 1'b0; now_n = 0;
    chk_a("t5_n0", 4'b1111, 1'b0);
    run_to(16);
    chk_a("t5_n16", 4'b1111, 1'b0);
    run_to(17);
    chk_a("t5_n17", 4'b1110, 1'b0);
    run_to(41);
    chk_a("t5_n41", 4'b0000, 1'b1);

    // Test 2: zero hold and zero stagger release on the first free edge.
    rst_b = 1'b1;
    @(posedge clk); #1; rst_b = 1'b0; now_n = 0;
    chk("t2_reset_rst", {4'b0, if_b.o_rst}, 8'b0000_1111);
    chk("t2_reset_done", {7'b0, if_b.o_done}, 8'd0);
    run_to(1);
    chk("t2_n1_rst", {4'b0, if_b.o_rst}, 8'd0);
    chk("t2_n1_done", {7'b0, if_b.o_done}, 8'd1);
    chk("t2_n1_busy", {7'b0, if_b.o_busy}, 8'd0);

    // Test 6: single channel, long hold at counter limit.
    rst_c = 1'b1;
    @(posedge clk); #1; rst_c = 1'b0; now_n = 0;
    chk("t6_reset_rst", {7'b0, if_c.o_rst}, 8'd1);
    run_to(255);
    chk("t6_n255_rst", {7'b0, if_c.o_rst}, 8'd1);
    chk("t6_n255_done", {7'b0, if_c.o_done}, 8'd0);
    run_to(256);
    chk("t6_n256_rst", {7'b0, if_c.o_rst}, 8'd0);
    chk("t6_n256_done", {7'b0, if_c.o_done}, 8'd1);
    chk("t6_n256_busy", {7'b0, if_c.o_busy}, 8'd0);
    bad = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      if (if_c.o_rst !== 1'b0 || if_c.o_done !== 1'b1) bad = 1'b1;
    end
    chk("t6_stay_low", {7'b0, bad}, 8'd0);
    chk("t6_cnt_sat", dut_c.cnt_q, 8'd255);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
